// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the ID stage and the forwarding/hazard controller.
// master = ID-stage/datapath side, slave = the controller.
interface hazard_forward_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
);
  logic                       id_valid;
  logic [NUM_SRC*REG_AW-1:0]  id_src_reg;
  logic [NUM_SRC-1:0]         id_src_used;
  logic [REG_AW-1:0]          id_rd;
  logic                       id_reg_write;
  logic                       id_mem_read;
  logic                       flush;
  logic [2*NUM_SRC-1:0]       fwd_sel;
  logic                       stall;
  logic                       bubble;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output id_valid, id_src_reg, id_src_used, id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_sel, stall, bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_reg, id_src_used, id_rd, id_reg_write, id_mem_read, flush,
    output fwd_sel, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline; owns its EX/MEM(/WB) tag pipe.
// Optional feature: define FWD_WB_EN to keep a WB tag and forward from WB (fwd_sel 11).
module hazard_forward_ctrl #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_ctrl_if.slave bus
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              mr;
  } tag_t;

  // Past EX only liveness and index matter, so MEM/WB keep the reduced form.
  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] rd;
  } fwd_tag_t;

  typedef enum logic {RUN, STALL} state_t;

  state_t               state_q, state_d;
  tag_t                 ex_q, ex_d, id_tag;
  fwd_tag_t             mem_q, mem_d;
`ifdef FWD_WB_EN
  fwd_tag_t             wb_q;
`endif
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic                 ex_live, lu_match, lu, stall, bubble;

  function automatic logic tag_live(tag_t t);
    return t.v & t.wr & (t.rd != ZERO_IDX);
  endfunction

  assign ex_live = tag_live(ex_q);

  // Per-port bypass selection; the youngest producer is tested first.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [REG_AW-1:0] src;
    src      = '0;
    fwd_sel  = '0;
    lu_match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = bus.id_src_reg[k*REG_AW +: REG_AW];
      if (bus.id_src_used[k] && src != ZERO_IDX) begin
        if (ex_live && ex_q.rd == src) begin
          fwd_sel[2*k +: 2] = 2'b10;
          if (ex_q.mr) lu_match = 1'b1;
        end else if (mem_q.live && mem_q.rd == src) begin
          fwd_sel[2*k +: 2] = 2'b01;
`ifdef FWD_WB_EN
        end else if (wb_q.live && wb_q.rd == src) begin
          fwd_sel[2*k +: 2] = 2'b11;
`endif
        end
      end
    end
  end

  // Flush is folded into lu, so a squashed instruction can never stall.
  assign lu = bus.id_valid & ~bus.flush & lu_match;

  // STALL always returns to RUN: the stalled cycle put a bubble into EX, so no second load-use can arise.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (lu) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = STALL;
        end
      end
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    id_tag = '{v: bus.id_valid, rd: bus.id_rd, wr: bus.id_reg_write, mr: bus.id_mem_read};
    ex_d   = '0;
    if (bus.id_valid && !bus.flush && !stall) ex_d = id_tag;
    mem_d  = '{live: ex_live, rd: ex_q.rd};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the tag pipe is reset in full; a stale valid bit would forward or stall on garbage after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
`ifdef FWD_WB_EN
      wb_q        <= '0;
`endif
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
`ifdef FWD_WB_EN
      wb_q    <= mem_q;
`endif
      if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl; counter narrowed to 3 bits so saturation is reachable.
module tb_hazard_forward_ctrl;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 3;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_forward_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_forward_ctrl #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .ZERO_REG(31), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic wr, input logic mr, input logic fl);
    bus.id_valid     = v;
    bus.id_src_reg   = {s1, s0};
    bus.id_src_used  = used;
    bus.id_rd        = rd;
    bus.id_reg_write = wr;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] fwd, input logic st, input logic bb);
    #1;
    check({tag, ".fwd"}, 32'(bus.fwd_sel), 32'(fwd));
    check({tag, ".stall"}, 32'(bus.stall), 32'(st));
    check({tag, ".bubble"}, 32'(bus.bubble), 32'(bb));
  endtask

  initial begin
    logic [3:0] wb_exp;
    int         cnt_exp;

    // Reset held while an X1 producer and consumer sit in ID.
    reset = 1'b0;
    set_id(1, 5'd1, 5'd1, 2'b11, 5'd1, 1, 1, 0);
    tick();
    tick();
    chk_out("rst", 4'b0000, 0, 0);
    check("rst.cnt", 32'(bus.stall_cnt), 0);
    reset = 1'b1;
    idle(3);

    // ADD X1 ; SUB X2,X1,X1 ; AND X6,X1,X2
    set_id(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 0);
    chk_out("add", 4'b0000, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd1, 2'b11, 5'd2, 1, 0, 0);
    chk_out("sub", 4'b1010, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd2, 2'b11, 5'd6, 1, 0, 0);
    chk_out("and", 4'b1001, 0, 0);
    tick();
    idle(3);

    // LDUR X3 ; ADD X4,X3,X5 -> exactly one stall cycle
    set_id(1, 5'd4, 5'd0, 2'b01, 5'd3, 1, 1, 0);
    tick();
    set_id(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 0, 0);
    chk_out("lu", 4'b0010, 1, 1);
    check("lu.cnt0", 32'(bus.stall_cnt), 0);
    tick();
    chk_out("lu.after", 4'b0001, 0, 0);
    check("lu.cnt1", 32'(bus.stall_cnt), 1);
    tick();
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    check("lu.cnt_hold", 32'(bus.stall_cnt), 1);
    idle(3);

    // X1 written in both EX and MEM: EX wins
    set_id(1, 5'd7, 5'd8, 2'b11, 5'd1, 1, 0, 0);
    tick();
    set_id(1, 5'd7, 5'd8, 2'b11, 5'd1, 1, 0, 0);
    chk_out("nomatch", 4'b0000, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd1, 2'b11, 5'd9, 1, 0, 0);
    chk_out("youngest", 4'b1010, 0, 0);
    tick();
    idle(3);

    // Load into X31 never forwards or stalls
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd31, 1, 1, 0);
    tick();
    set_id(1, 5'd31, 5'd31, 2'b11, 5'd2, 1, 0, 0);
    chk_out("zero", 4'b0000, 0, 0);
    tick();
    idle(3);

    // Unused port suppresses select and stall; invalid ID still computes fwd_sel
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 1, 0);
    tick();
    set_id(1, 5'd9, 5'd9, 2'b00, 5'd2, 1, 0, 0);
    chk_out("unused", 4'b0000, 0, 0);
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 1, 0);
    tick();
    set_id(0, 5'd9, 5'd0, 2'b01, 5'd2, 1, 0, 0);
    chk_out("novalid", 4'b0010, 0, 0);
    tick();
    idle(3);

    // Load-use with flush in the same cycle: no stall, flushed ADD X4 becomes a bubble
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 0);
    tick();
    set_id(1, 5'd3, 5'd0, 2'b01, 5'd4, 1, 0, 1);
    chk_out("flush", 4'b0010, 0, 0);
    tick();
    set_id(1, 5'd4, 5'd3, 2'b11, 5'd5, 1, 0, 0);
    chk_out("flush.ex_bubble", 4'b0100, 0, 0);
    check("flush.cnt", 32'(bus.stall_cnt), 1);
    tick();
    idle(3);

    // Producer three instructions back: only reachable through WB forwarding
`ifdef FWD_WB_EN
    wb_exp = 4'b0011;
`else
    wb_exp = 4'b0000;
`endif
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd10, 1, 0, 0);
    tick();
    idle(2);
    set_id(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 0, 0);
    chk_out("wb", wb_exp, 0, 0);
    tick();
    idle(3);

    // Repeated load-use until the 3-bit counter saturates at 7
    for (int i = 0; i < 7; i++) begin
      cnt_exp = (i + 2 > 7) ? 7 : i + 2;
      set_id(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 0);
      tick();
      set_id(1, 5'd3, 5'd0, 2'b01, 5'd4, 1, 0, 0);
      #1;
      check($sformatf("sat%0d.stall", i), 32'(bus.stall), 1);
      tick();
      check($sformatf("sat%0d.cnt", i), 32'(bus.stall_cnt), 32'(cnt_exp));
      tick();
      idle(1);
    end

    // Reset asserted mid-stall drops the stall at once
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 0);
    tick();
    set_id(1, 5'd3, 5'd0, 2'b01, 5'd4, 1, 0, 0);
    #1;
    check("midrst.pre_stall", 32'(bus.stall), 1);
    reset = 1'b0;
    chk_out("midrst", 4'b0000, 0, 0);
    check("midrst.cnt", 32'(bus.stall_cnt), 0);
    reset = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
